pixel_frame_reader: RTL

Frame source for the pixel pipeline: holds one WIDTH×HEIGHT 8-bit grayscale frame in internal RAM and streams it in raster order to the threshold/median processing stage. It is the producer end of the pixel stream that the processing stage consumes. It is filled through a simple write port and streamed on a start pulse. Output is valid/ready with start-of-frame, end-of-line and end-of-frame markers plus row/column coordinates, so the consumer can apply its border rules without keeping its own counters.

---
 rtl/pixel_frame_reader.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/pixel_frame_reader.sv
// pixel_frame_reader: holds one WIDTH x HEIGHT frame in internal RAM and streams it in
// raster order over a valid/ready interface with sof/eol/eof markers and row/col coordinates.
//
// Ports:
//   clk, reset (async, active-low)
//   wr_en/wr_addr/wr_data : frame RAM write port, honoured only while idle
//   start                 : one-cycle pulse that begins streaming (ignored unless idle)
//   busy, frame_done      : status; frame_done pulses once after the last pixel is accepted
//   out_valid/out_ready   : stream handshake
//   out_data/out_row/out_col/out_sof/out_eol/out_eof : pixel and its position markers
//   out_border            : only with PFR_BORDER_FLAG_EN defined; pixel lies on the frame edge
//
// Build option: define PFR_BORDER_FLAG_EN to add the out_border port and its logic.
module pixel_frame_reader #(
    parameter int WIDTH  = 64,
    parameter int HEIGHT = 64,
    parameter int DW     = 8,
    parameter int AW     = $clog2(WIDTH * HEIGHT)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_en,
    input  logic [AW-1:0]             wr_addr,
    input  logic [DW-1:0]             wr_data,
    input  logic                      start,
    output logic                      busy,
    output logic                      frame_done,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DW-1:0]             out_data,
    output logic [$clog2(HEIGHT)-1:0] out_row,
    output logic [$clog2(WIDTH)-1:0]  out_col,
    output logic                      out_sof,
    output logic                      out_eol,
    output logic                      out_eof
`ifdef PFR_BORDER_FLAG_EN
    ,
    output logic                      out_border
`endif
);
    localparam int N  = WIDTH * HEIGHT;
    localparam int RW = $clog2(HEIGHT);
    localparam int CW = $clog2(WIDTH);

    localparam logic [RW-1:0] ROW_LAST  = RW'(HEIGHT - 1);
    localparam logic [CW-1:0] COL_LAST  = CW'(WIDTH - 1);
    localparam logic [AW-1:0] ADDR_LAST = AW'(N - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    logic [1:0]    state, state_next;
    logic [DW-1:0] mem [N];

    logic [AW-1:0] rd_addr;
    logic [RW-1:0] rd_row;
    logic [CW-1:0] rd_col;
    logic          rd_finished;

    logic [DW-1:0] fifo_data [2];
    logic [RW-1:0] fifo_row  [2];
    logic [CW-1:0] fifo_col  [2];
    logic          fifo_wptr, fifo_rptr;
    logic [1:0]    fifo_count;

    logic          rd_issue, pop, head_eof;
    logic [RW-1:0] head_row;
    logic [CW-1:0] head_col;

    assign head_row = fifo_row[fifo_rptr];
    assign head_col = fifo_col[fifo_rptr];
    assign head_eof = (head_row == ROW_LAST) && (head_col == COL_LAST);
    assign pop      = out_valid && out_ready;
    // The RAM read lands straight in the FIFO on the issuing edge, so the only
    // in-flight read is this cycle's; issue when a slot is free after any pop.
    assign rd_issue = (state == ST_STREAM) && !rd_finished && ((fifo_count < 2'd2) || pop);

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (start) state_next = ST_STREAM;
            ST_STREAM: if (pop && head_eof) state_next = ST_DONE;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Read counter: raster address plus the row/col that travel with the data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_addr     <= '0;
            rd_row      <= '0;
            rd_col      <= '0;
            rd_finished <= 1'b0;
        end else if (state == ST_IDLE && start) begin
            rd_addr     <= '0;
            rd_row      <= '0;
            rd_col      <= '0;
            rd_finished <= 1'b0;
        end else if (rd_issue) begin
            if (rd_addr == ADDR_LAST) begin
                rd_finished <= 1'b1;
            end else begin
                rd_addr <= rd_addr + 1'b1;
                if (rd_col == COL_LAST) begin
                    rd_col <= '0;
                    rd_row <= rd_row + 1'b1;
                end else begin
                    rd_col <= rd_col + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_IDLE && wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Pixel data is not reset; outputs are masked by out_valid instead.
    always_ff @(posedge clk) begin
        if (rd_issue) begin
            fifo_data[fifo_wptr] <= mem[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fifo_row[0] <= '0;
            fifo_row[1] <= '0;
            fifo_col[0] <= '0;
            fifo_col[1] <= '0;
            fifo_wptr   <= 1'b0;
            fifo_rptr   <= 1'b0;
            fifo_count  <= 2'd0;
        end else begin
            if (rd_issue) begin
                fifo_row[fifo_wptr] <= rd_row;
                fifo_col[fifo_wptr] <= rd_col;
                fifo_wptr           <= ~fifo_wptr;
            end
            if (pop) begin
                fifo_rptr <= ~fifo_rptr;
            end
            if (rd_issue && !pop) begin
                fifo_count <= fifo_count + 2'd1;
            end else if (pop && !rd_issue) begin
                fifo_count <= fifo_count - 2'd1;
            end
        end
    end

`ifdef PFR_BORDER_FLAG_EN
    logic fifo_border [2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fifo_border[0] <= 1'b0;
            fifo_border[1] <= 1'b0;
        end else if (rd_issue) begin
            fifo_border[fifo_wptr] <= (rd_row == '0) || (rd_row == ROW_LAST) ||
                                      (rd_col == '0) || (rd_col == COL_LAST);
        end
    end

    assign out_border = out_valid && fifo_border[fifo_rptr];
`endif

    assign busy       = (state != ST_IDLE);
    assign frame_done = (state == ST_DONE);
    assign out_valid  = (fifo_count != 2'd0);
    assign out_data   = out_valid ? fifo_data[fifo_rptr] : '0;
    assign out_row    = out_valid ? head_row : '0;
    assign out_col    = out_valid ? head_col : '0;
    assign out_sof    = out_valid && (head_row == '0) && (head_col == '0);
    assign out_eol    = out_valid && (head_col == COL_LAST);
    assign out_eof    = out_valid && head_eof;

endmodule
